adc_frame_uart_tx: RTL and testbench

//  Serialises 12-bit ADC samples to the host over 8N1 UART on the TinyFPGA bring-up board.

---
 rtl/adc_frame_uart_tx.sv | 147 ++++++++++++++
 tb/tb_adc_frame_uart_tx.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_frame_uart_tx.sv
// Frames each accepted 12-bit ADC sample as four 8N1 UART bytes:
// header, {seq, sample[11:8]}, sample[7:0], XOR checksum of the first three.
//
//   state | meaning
//   IDLE  | line high, s_ready high, waiting for a sample
//   START | start bit (low) of the byte selected by byte_idx
//   DATA  | eight data bits, LSB first
//   STOP  | stop bit (high); back to START for the next byte, IDLE after byte 3
module adc_frame_uart_tx #(
    parameter int unsigned CLK_HZ   = 16000000,
    parameter int unsigned BAUD     = 115200,
    parameter logic [7:0]  HDR_BYTE = 8'hA5
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        s_valid,
    input  logic [11:0] s_data,
    output logic        s_ready,
    output logic        uart_tx,
    output logic        frame_done,
    output logic [3:0]  seq
);

    // CLKS_PER_BIT must be at least 2 so frame_done can be registered one cycle ahead.
    localparam int unsigned CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int unsigned CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] DONE_AT  = CNT_W'(CLKS_PER_BIT - 2);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_idx;
    logic [1:0]       byte_idx;
    logic [6:0]       shreg;
    logic [11:0]      frame_data;
    logic [3:0]       frame_seq;

    logic [7:0] byte1;
    logic [7:0] byte2;
    logic [7:0] byte3;
    logic [7:0] cur_byte;
    logic       bit_end;

    assign byte1   = {frame_seq, frame_data[11:8]};
    assign byte2   = frame_data[7:0];
    assign byte3   = HDR_BYTE ^ byte1 ^ byte2;
    assign bit_end = (baud_cnt == BIT_LAST);
    assign s_ready = (state == IDLE);

    always_comb begin
        cur_byte = HDR_BYTE;
        case (byte_idx)
            2'd0:    cur_byte = HDR_BYTE;
            2'd1:    cur_byte = byte1;
            2'd2:    cur_byte = byte2;
            default: cur_byte = byte3;
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state      <= IDLE;
            baud_cnt   <= '0;
            bit_idx    <= '0;
            byte_idx   <= '0;
            shreg      <= '0;
            frame_data <= '0;
            frame_seq  <= '0;
            uart_tx    <= 1'b1;
            frame_done <= 1'b0;
            seq        <= '0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    uart_tx  <= 1'b1;
                    baud_cnt <= '0;
                    if (s_valid) begin
                        frame_data <= s_data;
                        frame_seq  <= seq;
                        byte_idx   <= '0;
                        uart_tx    <= 1'b0;
                        state      <= START;
                    end
                end

                START: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        uart_tx  <= cur_byte[0];
                        shreg    <= cur_byte[7:1];
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                DATA: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            uart_tx <= 1'b1;
                            state   <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            uart_tx <= shreg[0];
                            shreg   <= shreg >> 1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                STOP: begin
                    // Registered one cycle early so the pulse lands on the last stop-bit cycle.
                    if (baud_cnt == DONE_AT && byte_idx == 2'd3) begin
                        frame_done <= 1'b1;
                    end
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (byte_idx == 2'd3) begin
                            seq   <= seq + 1'b1;
                            state <= IDLE;
                        end else begin
                            byte_idx <= byte_idx + 1'b1;
                            uart_tx  <= 1'b0;
                            state    <= START;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adc_frame_uart_tx.sv
// Self-checking bench for adc_frame_uart_tx: line-level UART decoder feeding a byte scoreboard,
// plus cycle-exact line/handshake checks. Runs at a reduced clock rate (10 clocks per bit).
`timescale 1ns/1ps
module tb_adc_frame_uart_tx;

    localparam int unsigned CLK_HZ = 1200000;
    localparam int unsigned BAUD   = 115200;
    localparam int CPB   = CLK_HZ / BAUD;
    localparam int FRAME = 40 * CPB;
    localparam int BOUND = 3 * FRAME;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        s_valid = 1'b0;
    logic [11:0] s_data  = '0;
    logic        s_ready;
    logic        uart_tx;
    logic        frame_done;
    logic [3:0]  seq;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q[$];
    logic [7:0] rx_log[$];
    logic [3:0] model_seq = '0;
    int         acc_count = 0;
    logic [7:0] sb_b1, sb_b2;

    bit         rx_busy = 0;
    bit         rx_ok   = 0;
    int         rx_cnt  = 0;
    int         rx_bit  = 0;
    logic [7:0] rx_sh   = '0;
    logic [7:0] rx_exp;

    typedef struct {
        logic [11:0] data;
        logic [7:0]  b1;
        logic [7:0]  b2;
        logic [7:0]  b3;
    } vec_t;
    vec_t tbl[4];

    adc_frame_uart_tx #(
        .CLK_HZ   (CLK_HZ),
        .BAUD     (BAUD),
        .HDR_BYTE (8'hA5)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_ready    (s_ready),
        .uart_tx    (uart_tx),
        .frame_done (frame_done),
        .seq        (seq)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Scoreboard producer: a sample seen valid while ready (just before the edge) is accepted.
    always @(negedge sys_clk) begin
        #1;
        if (sys_rst) begin
            model_seq = '0;
            exp_q.delete();
        end else if (s_valid === 1'b1 && s_ready === 1'b1) begin
            sb_b1 = {model_seq, s_data[11:8]};
            sb_b2 = s_data[7:0];
            exp_q.push_back(8'hA5);
            exp_q.push_back(sb_b1);
            exp_q.push_back(sb_b2);
            exp_q.push_back(8'hA5 ^ sb_b1 ^ sb_b2);
            model_seq = model_seq + 4'd1;
            acc_count++;
        end
    end

    // UART decoder: samples each bit at its middle and compares against the scoreboard.
    always @(negedge sys_clk) begin
        if (sys_rst) begin
            rx_busy = 0;
        end else if (!rx_busy) begin
            if (uart_tx === 1'b0) begin
                rx_busy = 1;
                rx_cnt  = CPB / 2;
                rx_bit  = 0;
            end
        end else begin
            rx_cnt--;
            if (rx_cnt == 0) begin
                rx_cnt = CPB;
                if (rx_bit == 0) begin
                    rx_ok = (uart_tx === 1'b0);
                end else if (rx_bit <= 8) begin
                    rx_sh[rx_bit-1] = uart_tx;
                end else begin
                    if (uart_tx !== 1'b1) rx_ok = 0;
                    rx_log.push_back(rx_sh);
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL rx_byte unexpected actual=%02h required=none", rx_sh);
                    end else begin
                        rx_exp = exp_q.pop_front();
                        if (rx_sh !== rx_exp || !rx_ok) begin
                            errors++;
                            $display("FAIL rx_byte actual=%02h required=%02h framing_ok=%0d",
                                     rx_sh, rx_exp, rx_ok);
                        end
                    end
                    rx_busy = 0;
                end
                rx_bit++;
            end
        end
    end

    task automatic wait_ready(output bit ok);
        int n;
        n = 0;
        @(negedge sys_clk);
        while (s_ready !== 1'b1 && n < BOUND) begin
            @(negedge sys_clk);
            n++;
        end
        ok = (s_ready === 1'b1);
        if (!ok) chk("wait_ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic chk_frame(input string name, input int back,
                             input logic [7:0] e0, input logic [7:0] e1,
                             input logic [7:0] e2, input logic [7:0] e3);
        logic [7:0] e[4];
        int base;
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
        base = rx_log.size() - 4 * back;
        if (base < 0) begin
            chk({name, "_count"}, rx_log.size(), 4 * back);
        end else begin
            for (int i = 0; i < 4; i++)
                chk($sformatf("%s_b%0d", name, i), rx_log[base+i], e[i]);
        end
    endtask

    // One sample with a 1-cycle valid pulse; checks every line cycle and the handshake timing.
    task automatic run_frame(input logic [11:0] d, input logic [7:0] b1, input logic [7:0] b2,
                             input logic [7:0] b3, input logic [3:0] sq);
        logic [7:0] fb[4];
        logic [3:0] nsq;
        logic       eb;
        int line_err, rdy_err, fd_err, j, bi;
        bit ok;
        fb[0] = 8'hA5; fb[1] = b1; fb[2] = b2; fb[3] = b3;
        nsq = sq + 4'd1;
        line_err = 0; rdy_err = 0; fd_err = 0;
        wait_ready(ok);
        if (!ok) return;
        s_valid = 1'b1;
        s_data  = d;
        @(negedge sys_clk);
        s_valid = 1'b0;
        s_data  = ~d;
        for (int k = 1; k <= FRAME; k++) begin
            if (k > 1) @(negedge sys_clk);
            j  = (k - 1) / CPB;
            bi = j % 10;
            if (bi == 0)      eb = 1'b0;
            else if (bi == 9) eb = 1'b1;
            else              eb = fb[j/10][bi-1];
            if (uart_tx !== eb) line_err++;
            if (s_ready !== 1'b0) rdy_err++;
            if (frame_done !== (k == FRAME)) fd_err++;
        end
        chk("seq_before_end", seq, sq);
        @(negedge sys_clk);
        chk("line_bits", line_err, 0);
        chk("ready_low_in_frame", rdy_err, 0);
        chk("frame_done_pulse", fd_err, 0);
        chk("ready_after_frame", s_ready, 1);
        chk("line_idle_after", uart_tx, 1);
        chk("seq_incr", seq, nsq);
        chk_frame($sformatf("frame_%03h", d), 1, 8'hA5, b1, b2, b3);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        logic [11:0] d;
        logic [7:0]  b1, b2, b3;
        logic [3:0]  sq;
        int acc0, n, hi_err;
        bit ok;

        tbl[0] = '{data: 12'h3C7, b1: 8'h03, b2: 8'hC7, b3: 8'h61};
        tbl[1] = '{data: 12'hFFF, b1: 8'h1F, b2: 8'hFF, b3: 8'h45};
        tbl[2] = '{data: 12'h000, b1: 8'h20, b2: 8'h00, b3: 8'h85};
        tbl[3] = '{data: 12'h5A5, b1: 8'h35, b2: 8'hA5, b3: 8'h35};

        repeat (3) @(negedge sys_clk);
        chk("rst_uart_tx", uart_tx, 1);
        chk("rst_s_ready", s_ready, 1);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_seq", seq, 0);
        sys_rst = 1'b0;

        for (int i = 0; i < 4; i++)
            run_frame(tbl[i].data, tbl[i].b1, tbl[i].b2, tbl[i].b3, 4'(i));

        // s_valid held high across two frames, data changed after each acceptance.
        wait_ready(ok);
        acc0    = acc_count;
        s_valid = 1'b1;
        s_data  = 12'h123;
        @(negedge sys_clk);
        s_data  = 12'h456;
        repeat (FRAME - 1) @(negedge sys_clk);
        chk("hold_fd_last_stop", frame_done, 1);
        chk("hold_one_accept", acc_count - acc0, 1);
        @(negedge sys_clk);
        chk("hold_idle_line", uart_tx, 1);
        chk("hold_idle_ready", s_ready, 1);
        @(negedge sys_clk);
        chk("hold_restart_line", uart_tx, 0);
        chk("hold_restart_ready", s_ready, 0);
        s_valid = 1'b0;
        s_data  = 12'hABC;
        n = 0;
        while (frame_done !== 1'b1 && n < BOUND) begin
            @(negedge sys_clk);
            n++;
        end
        chk("hold_second_done", frame_done, 1);
        @(negedge sys_clk);
        chk("hold_two_accepts", acc_count - acc0, 2);
        chk_frame("hold_f1", 2, 8'hA5, 8'h41, 8'h23, 8'hC7);
        chk_frame("hold_f2", 1, 8'hA5, 8'h54, 8'h56, 8'hA7);

        // Reset while byte 2 data bits (all zero) are on the line.
        wait_ready(ok);
        s_valid = 1'b1;
        s_data  = 12'h100;
        @(negedge sys_clk);
        s_valid = 1'b0;
        repeat (22 * CPB + 2) @(negedge sys_clk);
        chk("pre_rst_line_low", uart_tx, 0);
        chk("pre_rst_seq", seq, 6);
        sys_rst = 1'b1;
        #1;
        chk("mid_rst_line", uart_tx, 1);
        chk("mid_rst_seq", seq, 0);
        chk("mid_rst_ready", s_ready, 1);
        chk("mid_rst_fd", frame_done, 0);
        repeat (3) @(negedge sys_clk);
        sys_rst = 1'b0;
        hi_err = 0;
        repeat (5 * CPB) begin
            @(negedge sys_clk);
            if (uart_tx !== 1'b1 || s_ready !== 1'b1) hi_err++;
        end
        chk("post_rst_no_resume", hi_err, 0);
        run_frame(12'h001, 8'h00, 8'h01, 8'hA4, 4'd0);

        // 17 random frames: seq field runs 1..15, 0, 1.
        sq = 4'd1;
        for (int i = 0; i < 17; i++) begin
            d  = 12'($urandom_range(0, 4095));
            b1 = {sq, d[11:8]};
            b2 = d[7:0];
            b3 = 8'hA5 ^ b1 ^ b2;
            run_frame(d, b1, b2, b3, sq);
            sq = sq + 4'd1;
        end

        repeat (2) @(negedge sys_clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
